two_color_calibrator: RTL

//  Loads the (U,V) target pair for one of the two color-mask channels by averaging

---
 rtl/two_color_calibrator_if.sv | 31 +++
 rtl/two_color_calibrator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/two_color_calibrator_if.sv
// Pixel stream, calibration control and live target bundle for two_color_calibrator.
// The pixel source / controller side uses master; the calibrator uses slave.
// Widths follow YUV_WIDTH and must match the calibrator instance.
interface two_color_calibrator_if #(
  parameter int YUV_WIDTH = 8
);
  logic signed [YUV_WIDTH-1:0] U;
  logic signed [YUV_WIDTH-1:0] V;
  logic                        in_valid;
  logic                        sof;
  logic                        in_window;
  logic                        cal_start;
  logic                        cal_sel;
  logic                        busy;
  logic                        cal_done;
  logic                        cal_err;
  logic signed [YUV_WIDTH-1:0] uTarget1;
  logic signed [YUV_WIDTH-1:0] vTarget1;
  logic signed [YUV_WIDTH-1:0] uTarget2;
  logic signed [YUV_WIDTH-1:0] vTarget2;

  modport master (
    output U, V, in_valid, sof, in_window, cal_start, cal_sel,
    input  busy, cal_done, cal_err, uTarget1, vTarget1, uTarget2, vTarget2
  );

  modport slave (
    input  U, V, in_valid, sof, in_window, cal_start, cal_sel,
    output busy, cal_done, cal_err, uTarget1, vTarget1, uTarget2, vTarget2
  );
endinterface

// File: rtl/two_color_calibrator.sv
// Averages in-window (U,V) over one frame and commits it as a two-color mask target pair.
// Latency: closing sof to cal_done = SUM_W+1 cycles; live targets swap only on a later sof.
// No backpressure: pixels are consumed every valid cycle. Optional macro CAL_ROUND_EN rounds half away from zero.
module two_color_calibrator #(
  parameter int YUV_WIDTH = 8,
  parameter int CNT_WIDTH = 20,
  parameter int U1_INIT   = -40,
  parameter int V1_INIT   = 60,
  parameter int U2_INIT   = 50,
  parameter int V2_INIT   = -30
) (
  input  logic clk,
  input  logic reset,
  two_color_calibrator_if.slave bus
);
  localparam int SUM_W  = YUV_WIDTH + CNT_WIDTH;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam logic signed [SUM_W:0] QMAX = (SUM_W+1)'(2**(YUV_WIDTH-1) - 1);
  localparam logic signed [SUM_W:0] QMIN = ~QMAX;

  typedef enum logic [2:0] {IDLE, ARM, ACCUM, DIVIDE, COMMIT} state_t;
  state_t state, state_nxt;

  logic                        sel;
  logic signed [SUM_W-1:0]     sum_u, sum_v;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [SUM_W-1:0]            dvd_u, dvd_v;     // dividend in, quotient out
  logic [CNT_WIDTH:0]          rem_u, rem_v;
  logic                        neg_u, neg_v;
  logic [STEP_W-1:0]           step;
  logic signed [YUV_WIDTH-1:0] stage_u, stage_v;
  logic                        stage_sel;
  logic                        pending;
  logic signed [YUV_WIDTH-1:0] u1, v1, u2, v2;
  logic                        busy, cal_done, cal_err;

  logic                        pix_sof, pix_win, cnt_full;
  logic signed [SUM_W-1:0]     u_ext, v_ext;
  logic [SUM_W-1:0]            rnd;
  logic [CNT_WIDTH:0]          rem_sh_u, rem_sh_v;
  logic                        ge_u, ge_v;
  logic signed [SUM_W:0]       qs_u, qs_v;

  assign pix_sof  = bus.in_valid & bus.sof;
  assign pix_win  = bus.in_valid & bus.in_window;
  assign cnt_full = &cnt;
  assign u_ext    = {{CNT_WIDTH{bus.U[YUV_WIDTH-1]}}, bus.U};
  assign v_ext    = {{CNT_WIDTH{bus.V[YUV_WIDTH-1]}}, bus.V};

`ifdef CAL_ROUND_EN
  assign rnd = SUM_W'(cnt >> 1);
`else
  assign rnd = '0;
`endif

  // Magnitude of a signed sum; the most negative value maps to 2^(SUM_W-1).
  function automatic logic [SUM_W-1:0] mag(input logic signed [SUM_W-1:0] s);
    logic [SUM_W-1:0] x;
    x = s;
    return s[SUM_W-1] ? (~x + SUM_W'(1)) : x;
  endfunction

  // Saturate a signed quotient into the target range.
  function automatic logic signed [YUV_WIDTH-1:0] clamp(input logic signed [SUM_W:0] q);
    logic signed [SUM_W:0] c;
    c = q;
    if (q > QMAX) c = QMAX;
    if (q < QMIN) c = QMIN;
    return c[YUV_WIDTH-1:0];
  endfunction

  // One restoring-division step for both channels, plus signed quotients for commit.
  always_comb begin
    rem_sh_u = {rem_u[CNT_WIDTH-1:0], dvd_u[SUM_W-1]};
    rem_sh_v = {rem_v[CNT_WIDTH-1:0], dvd_v[SUM_W-1]};
    ge_u     = rem_sh_u >= {1'b0, cnt};
    ge_v     = rem_sh_v >= {1'b0, cnt};
    qs_u     = $signed({1'b0, dvd_u});
    qs_v     = $signed({1'b0, dvd_v});
    if (neg_u) qs_u = -qs_u;
    if (neg_v) qs_v = -qs_v;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    cal_done  = 1'b0;
    cal_err   = 1'b0;
    case (state)
      IDLE:   if (bus.cal_start) state_nxt = ARM;
      ARM:    if (pix_sof) state_nxt = ACCUM;
      ACCUM:  if (pix_sof) state_nxt = DIVIDE;
      DIVIDE: begin
        if (cnt == '0) begin
          cal_err   = 1'b1;
          state_nxt = IDLE;
        end else if (step == STEP_W'(SUM_W - 1)) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        cal_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulation, division and staging datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= 1'b0;
      sum_u     <= '0;
      sum_v     <= '0;
      cnt       <= '0;
      dvd_u     <= '0;
      dvd_v     <= '0;
      rem_u     <= '0;
      rem_v     <= '0;
      neg_u     <= 1'b0;
      neg_v     <= 1'b0;
      step      <= '0;
      stage_u   <= '0;
      stage_v   <= '0;
      stage_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cal_start) begin
            sel   <= bus.cal_sel;
            sum_u <= '0;
            sum_v <= '0;
            cnt   <= '0;
          end
        end
        ARM: begin
          // The opening sof pixel already belongs to the frame.
          if (pix_sof && pix_win) begin
            sum_u <= sum_u + u_ext;
            sum_v <= sum_v + v_ext;
            cnt   <= cnt + CNT_WIDTH'(1);
          end
        end
        ACCUM: begin
          if (pix_sof) begin
            dvd_u <= mag(sum_u) + rnd;
            dvd_v <= mag(sum_v) + rnd;
            neg_u <= sum_u[SUM_W-1];
            neg_v <= sum_v[SUM_W-1];
            rem_u <= '0;
            rem_v <= '0;
            step  <= '0;
          end else if (pix_win && !cnt_full) begin
            // Saturated counter stops accumulation so the average stays consistent.
            sum_u <= sum_u + u_ext;
            sum_v <= sum_v + v_ext;
            cnt   <= cnt + CNT_WIDTH'(1);
          end
        end
        DIVIDE: begin
          step  <= step + STEP_W'(1);
          rem_u <= ge_u ? (rem_sh_u - {1'b0, cnt}) : rem_sh_u;
          rem_v <= ge_v ? (rem_sh_v - {1'b0, cnt}) : rem_sh_v;
          dvd_u <= {dvd_u[SUM_W-2:0], ge_u};
          dvd_v <= {dvd_v[SUM_W-2:0], ge_v};
        end
        COMMIT: begin
          stage_u   <= clamp(qs_u);
          stage_v   <= clamp(qs_v);
          stage_sel <= sel;
        end
        default: ;
      endcase
    end
  end

  // Shadow update: staged pair reaches the mask only at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      u1      <= YUV_WIDTH'(U1_INIT);
      v1      <= YUV_WIDTH'(V1_INIT);
      u2      <= YUV_WIDTH'(U2_INIT);
      v2      <= YUV_WIDTH'(V2_INIT);
    end else begin
      if (pix_sof && pending) begin
        pending <= 1'b0;
        if (stage_sel) begin
          u2 <= stage_u;
          v2 <= stage_v;
        end else begin
          u1 <= stage_u;
          v1 <= stage_v;
        end
      end
      // A fresh result always wins over a same-cycle shadow copy.
      if (state == COMMIT) pending <= 1'b1;
    end
  end

  assign bus.busy     = busy;
  assign bus.cal_done = cal_done;
  assign bus.cal_err  = cal_err;
  assign bus.uTarget1 = u1;
  assign bus.vTarget1 = v1;
  assign bus.uTarget2 = u2;
  assign bus.vTarget2 = v2;
endmodule
